// File: rtl/req_encoder_16to4.sv
// req_encoder_16to4: sequential 16-to-4 request encoder.
// Request lines are captured into a pending set. One pending line per
// valid/ready transfer is granted as a 4-bit index and retired. Index bit
// order matches the 4-to-16 decoder: code[0] is the index MSB and code[3] is
// the index LSB.
// Optional feature: define ROUND_ROBIN_EN for rotating-priority selection.
// Without it, selection is fixed priority and the lowest index wins.
module req_encoder_16to4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      req,
  output logic [3:0]       code,
  output logic             valid,
  input  logic             ready,
  output logic [15:0]      pending,
  output logic [CNT_W-1:0] merge_cnt
);

  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reverses bit order between a binary index and the decoder-ordered code.
  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  logic [3:0]       sel_idx;
  logic             sel_found;
  logic             load;
  logic             grant;
  logic [15:0]      sel_mask;
  logic [15:0]      inflight_onehot;
  logic [15:0]      hit_vec;
  logic [4:0]       hit_cnt;
  logic [SUM_W-1:0] merge_sum;
  logic [CNT_W-1:0] merge_next;
  logic [15:0]      pending_next;

`ifdef ROUND_ROBIN_EN
  logic [3:0] rr_ptr;

  // Picks the first pending line at or after the rotate pointer, wrapping 15->0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_idx   = 4'd0;
    sel_found = 1'b0;
    // Walk the search order backwards so the earliest hit is the last write.
    for (int i = 15; i >= 0; i--) begin
      if (pending[4'(rr_ptr + 4'(i))]) begin
        sel_idx   = 4'(rr_ptr + 4'(i));
        sel_found = 1'b1;
      end
    end
  end

  // Advances the rotate pointer past each granted line; it moves only on a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 4'd0;
    end else if (grant) begin
      rr_ptr <= sel_idx + 4'd1;
    end
  end
`else
  // Picks the lowest-indexed pending line.
  always_comb begin
    sel_idx   = 4'd0;
    sel_found = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = 4'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  // The output register is free when empty or being consumed this edge.
  assign load  = !valid || ready;
  assign grant = load && sel_found;

  // Derives the grant mask, the in-flight line and the merge-hit count.
  always_comb begin
    sel_mask        = '0;
    inflight_onehot = '0;
    hit_cnt         = '0;
    if (grant) begin
      sel_mask[sel_idx] = 1'b1;
    end
    if (valid) begin
      inflight_onehot[rev4(code)] = 1'b1;
    end
    hit_vec = req & (pending | inflight_onehot);
    for (int i = 0; i < 16; i++) begin
      hit_cnt = hit_cnt + {4'd0, hit_vec[i]};
    end
  end

  // A req bit arriving on the line being granted wins and stays pending.
  assign pending_next = (pending & ~sel_mask) | req;

  // Saturating accumulate: the sum is computed wide enough never to wrap.
  assign merge_sum  = SUM_W'(merge_cnt) + SUM_W'(hit_cnt);
  assign merge_next = (merge_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : merge_sum[CNT_W-1:0];

  // Updates pending set, merge counter and the registered grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // see pre-edge values regardless of statement order.
    if (!rst_n) begin
      code      <= 4'd0;
      valid     <= 1'b0;
      pending   <= '0;
      merge_cnt <= '0;
    end else begin
      pending   <= pending_next;
      merge_cnt <= merge_next;
      if (load) begin
        if (sel_found) begin
          code  <= rev4(sel_idx);
          valid <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_encoder_16to4.sv
// Testbench for req_encoder_16to4: directed scenarios followed by random
// traffic, all checked against a set-based behavioural model of the encoder.
module tb_req_encoder_16to4;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      req;
  logic             ready;
  logic [3:0]       code;
  logic             valid;
  logic [15:0]      pending;
  logic [CNT_W-1:0] merge_cnt;

  int total  = 0;
  int passed = 0;

  // Reference state: a set of waiting lines, one in-flight line, a counter.
  bit       m_wait [16];
  bit       m_valid;
  int       m_line;
  int       m_merge;
  int       m_ptr;

  req_encoder_16to4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .code      (code),
    .valid     (valid),
    .ready     (ready),
    .pending   (pending),
    .merge_cnt (merge_cnt)
  );

  always #5 clk = ~clk;

  // Decoder ordering: code[0] carries index bit 3, code[3] carries index bit 0.
  function automatic logic [3:0] to_code(input int idx);
    logic [3:0] c;
    c[0] = idx[3];
    c[1] = idx[2];
    c[2] = idx[1];
    c[3] = idx[0];
    return c;
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = m_wait[i];
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    int hits;
    int start;
    int k;
    if (!rst_n) begin
      foreach (m_wait[i]) m_wait[i] = 1'b0;
      m_valid = 1'b0;
      m_line  = 0;
      m_merge = 0;
      m_ptr   = 0;
      return;
    end
    hits = 0;
    for (int i = 0; i < 16; i++)
      if (req[i] && (m_wait[i] || (m_valid && m_line == i))) hits++;
    m_merge = (m_merge + hits > CNT_MAX) ? CNT_MAX : m_merge + hits;
    if (!m_valid || ready) begin
`ifdef ROUND_ROBIN_EN
      start = m_ptr;
`else
      start = 0;
`endif
      k = -1;
      for (int off = 0; off < 16 && k < 0; off++)
        if (m_wait[(start + off) % 16]) k = (start + off) % 16;
      if (k >= 0) begin
        m_line    = k;
        m_valid   = 1'b1;
        m_wait[k] = 1'b0;
        m_ptr     = (k + 1) % 16;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++)
      if (req[i]) m_wait[i] = 1'b1;
  endtask

  // One clock edge: advance the model, then sample the DUT 1 ns after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".valid"},   32'(valid),     32'(m_valid));
    check({tag, ".code"},    32'(code),      32'(to_code(m_line)));
    check({tag, ".pending"}, 32'(pending),   32'(model_pending()));
    check({tag, ".merge"},   32'(merge_cnt), 32'(m_merge));
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    req   = 16'hFFFF;
    ready = 1'b0;
    m_valid = 1'b0; m_line = 0; m_merge = 0; m_ptr = 0;
    foreach (m_wait[i]) m_wait[i] = 1'b0;
    #2;

    // Reset held for two edges with all request lines high.
    step("rst0");
    step("rst1");
    check("rst_valid",   32'(valid),     32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_merge",   32'(merge_cnt), 32'd0);

    // Single request on line 6 with the consumer always ready.
    rst_n = 1'b1; req = 16'h0040; ready = 1'b1;
    step("t2a");
    req = 16'h0000;
    step("t2b");
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_code",  32'(code),  32'b0110);
    step("t2c");
    check("t2_idle",    32'(valid),   32'd0);
    check("t2_pending", 32'(pending), 32'd0);

    // Lines 0 and 15 together while the consumer stalls.
    ready = 1'b0; req = 16'h8001;
    step("t3a");
    req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step("t3hold");
      check("t3_code",    32'(code),    32'(to_code(0)));
      check("t3_pending", 32'(pending), 32'h8000);
    end
    ready = 1'b1;
    step("t3b");
    check("t3_line15", 32'(code), 32'(to_code(15)));
    step("t3c");

    // Line 3 in flight, hit once while in flight and once while pending.
    ready = 1'b0; req = 16'h0008;
    step("t4a");
    req = 16'h0000;
    step("t4b");
    req = 16'h0008;
    step("t4c");
    check("t4_merge1", 32'(merge_cnt), 32'd1);
    req = 16'h0000;
    step("t4d");
    req = 16'h0008;
    step("t4e");
    check("t4_merge2", 32'(merge_cnt), 32'd2);
    req = 16'h0000; ready = 1'b1;
    step("t4f");
    check("t4_regrant", 32'(code), 32'(to_code(3)));
    check("t4_valid",   32'(valid), 32'd1);
    step("t4g");
    check("t4_done", 32'(valid), 32'd0);

    // Grant line 4 first (rotate pointer lands on 5), then all 16 lines at once.
    req = 16'h0010;
    step("t5a");
    req = 16'h0000;
    step("t5b");
    req = 16'hFFFF;
    step("t5c");
    req = 16'h0000;
`ifdef ROUND_ROBIN_EN
    first = 5;
`else
    first = 0;
`endif
    for (int i = 0; i < 16; i++) begin
      step("t5grant");
      check("t5_order", 32'(code),  32'(to_code((first + i) % 16)));
      check("t5_valid", 32'(valid), 32'd1);
    end
    step("t5end");
    check("t5_drained", 32'(valid), 32'd0);

    // Reset in the middle of a stalled transfer with lines 8..11 pending.
    ready = 1'b0; req = 16'h0001;
    step("t6a");
    req = 16'h0000;
    step("t6b");
    req = 16'h0F00;
    step("t6c");
    check("t6_pre", 32'(pending), 32'h0F00);
    req = 16'h0000; rst_n = 1'b0;
    step("t6rst");
    check("t6_valid",   32'(valid),   32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    rst_n = 1'b1; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("t6post");
      check("t6_stale", 32'(valid), 32'd0);
    end

    // Counter saturation: all lines requested every cycle while stalled.
    ready = 1'b0; req = 16'hFFFF;
    for (int i = 0; i < 24; i++) step("sat");
    check("sat_max", 32'(merge_cnt), 32'(CNT_MAX));
    req = 16'h0000; rst_n = 1'b0;
    step("sat_rst");
    rst_n = 1'b1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      req   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
